fpga_rst_seq: RTL and testbench

FPGA reset sequencer between the board reset sources and the SoC/DRAM reset inputs in the Xilinx top level. It synchronizes and debounces the board reset button, waits for clock-wizard lock, and holds the DRAM wrapper in reset for a fixed time. It then waits for DRAM calibration, with a timeout and retry, and only then releases the SoC reset that feeds `rstgen`. Any reset request or loss of lock restarts the sequence.

---
 rtl/fpga_rst_pkg.sv | 14 +
 rtl/fpga_btn_debounce.sv | 54 +++++
 rtl/sync.sv | 29 ++
 rtl/fpga_rst_seq.sv | 163 ++++++++++++++++
 tb/tb_fpga_rst_seq.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpga_rst_pkg.sv
// rtl/fpga_rst_pkg.sv - shared types for the FPGA reset sequencer
// Purpose: sequencer state encoding, also exported on state_o for ILA/debug.
package fpga_rst_pkg;

    typedef enum logic [2:0] {
        ST_RESET      = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_DRAM_RST   = 3'd2,
        ST_WAIT_CALIB = 3'd3,
        ST_SOC_RST    = 3'd4,
        ST_RUN        = 3'd5
    } fpga_rst_state_e;

endpackage

// File: rtl/fpga_btn_debounce.sv
// rtl/fpga_btn_debounce.sv - board reset button synchronizer and debouncer
// Purpose: the debounced level only follows the synchronized button after it
//          has disagreed with it for DebounceCycles consecutive cycles.
// Ports:
//   clk_i     SoC clock
//   rst_i     synchronous active-high reset
//   btn_i     raw asynchronous button level, active-high
//   btn_db_o  debounced button level, resets to 0
module fpga_btn_debounce #(
    parameter int unsigned DebounceCycles = 50000,
    parameter int unsigned CntWidth       = 32
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic btn_db_o
);

    localparam logic [CntWidth-1:0] DbLast = CntWidth'(DebounceCycles - 1);

    logic                btn_s;
    logic [CntWidth-1:0] cnt_q;
    logic                db_q;

    sync #(
        .STAGES(2)
    ) u_sync_btn (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .serial_i(btn_i),
        .serial_o(btn_s)
    );

    // The counter measures how long btn_s has disagreed with the debounced
    // value; any agreeing cycle restarts the measurement.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            db_q  <= 1'b0;
        end else if (btn_s != db_q) begin
            if (cnt_q == DbLast) begin
                db_q  <= btn_s;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else begin
            cnt_q <= '0;
        end
    end

    assign btn_db_o = db_q;

endmodule

// File: rtl/sync.sv
// rtl/sync.sv - multi-flop synchronizer cell for single-bit async inputs
// Purpose: bring an asynchronous level into the clk_i domain.
// Ports:
//   clk_i     destination clock
//   rst_i     synchronous active-high reset, clears every stage to 0
//   serial_i  asynchronous input level
//   serial_o  synchronized level, STAGES cycles behind serial_i
module sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic serial_i,
    output logic serial_o
);

    logic [STAGES-1:0] reg_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            reg_q <= '0;
        end else begin
            reg_q <= {reg_q[STAGES-2:0], serial_i};
        end
    end

    assign serial_o = reg_q[STAGES-1];

endmodule

// File: rtl/fpga_rst_seq.sv
// rtl/fpga_rst_seq.sv - FPGA reset sequencer for the DRAM wrapper and SoC
// Purpose: debounce the board button, wait for clock lock, pulse the DRAM
//          reset, wait for calibration (timeout + retry), then release the SoC.
// Ports:
//   clk_i            SoC clock
//   rst_i            synchronous active-high reset
//   btn_rst_i        raw board reset button (async, active-high)
//   vio_rst_i        VIO reset request (clk_i domain)
//   clk_locked_i     clock-wizard lock (async)
//   calib_done_i     DRAM calibration done (DRAM clock domain)
//   dram_rst_o       DRAM wrapper reset, active-high
//   soc_rst_no       SoC reset, active-low
//   calib_timeout_o  sticky calibration-timeout flag
//   state_o          current sequencer state
module fpga_rst_seq
    import fpga_rst_pkg::*;
#(
    parameter int unsigned DebounceCycles = 50000,
    parameter int unsigned DramRstCycles  = 16,
    parameter int unsigned SocRstCycles   = 32,
    parameter int unsigned CalibTimeout   = 50_000_000,
    parameter bit          UseDram        = 1'b1,
    parameter int unsigned CntWidth       = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       btn_rst_i,
    input  logic       vio_rst_i,
    input  logic       clk_locked_i,
    input  logic       calib_done_i,
    output logic       dram_rst_o,
    output logic       soc_rst_no,
    output logic       calib_timeout_o,
    output logic [2:0] state_o
);

    localparam logic [CntWidth-1:0] DramLast  = CntWidth'(DramRstCycles - 1);
    localparam logic [CntWidth-1:0] SocLast   = CntWidth'(SocRstCycles - 1);
    localparam logic [CntWidth-1:0] CalibLast = CntWidth'(CalibTimeout - 1);

    logic btn_db;
    logic lock_s;
    logic calib_s;
    logic abort;

    fpga_rst_state_e     state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                tmo_q, tmo_d;
    logic                dram_rst_q;
    logic                soc_rst_nq;

    fpga_btn_debounce #(
        .DebounceCycles(DebounceCycles),
        .CntWidth      (CntWidth)
    ) u_btn_debounce (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .btn_i   (btn_rst_i),
        .btn_db_o(btn_db)
    );

    sync #(
        .STAGES(2)
    ) u_sync_lock (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .serial_i(clk_locked_i),
        .serial_o(lock_s)
    );

    sync #(
        .STAGES(2)
    ) u_sync_calib (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .serial_i(calib_done_i),
        .serial_o(calib_s)
    );

    assign abort = btn_db | vio_rst_i | ~lock_s;

    // One counter is shared by every timed state; each transition into a
    // timed state clears it, so it always reads "cycles spent in this state".
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        tmo_d   = tmo_q;
        case (state_q)
            ST_RESET: begin
                state_d = ST_WAIT_LOCK;
                cnt_d   = '0;
            end
            ST_WAIT_LOCK: begin
                cnt_d = '0;
                if (!abort) begin
                    state_d = ST_DRAM_RST;
                end
            end
            ST_DRAM_RST: begin
                if (cnt_q == DramLast) begin
                    state_d = UseDram ? ST_WAIT_CALIB : ST_SOC_RST;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_CALIB: begin
                // Calibration is checked first so a same-cycle timeout is
                // not counted as a failure.
                if (calib_s) begin
                    state_d = ST_SOC_RST;
                    cnt_d   = '0;
                end else if (cnt_q == CalibLast) begin
                    tmo_d   = 1'b1;
                    state_d = ST_DRAM_RST;
                    cnt_d   = '0;
                end
            end
            ST_SOC_RST: begin
                if (cnt_q == SocLast) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                cnt_d = '0;
            end
            default: begin
                state_d = ST_RESET;
                cnt_d   = '0;
            end
        endcase
        // Abort overrides every normal transition, including a timeout.
        if (abort && (state_q != ST_RESET)) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
            tmo_d   = tmo_q;
        end
    end

    // Reset outputs are loaded from state_d so they change on the same edge
    // as state_o and never glitch.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_RESET;
            cnt_q      <= '0;
            tmo_q      <= 1'b0;
            dram_rst_q <= 1'b1;
            soc_rst_nq <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            dram_rst_q <= (state_d == ST_RESET) || (state_d == ST_WAIT_LOCK) ||
                          (state_d == ST_DRAM_RST);
            soc_rst_nq <= (state_d == ST_RUN);
        end
    end

    assign dram_rst_o      = dram_rst_q;
    assign soc_rst_no      = soc_rst_nq;
    assign calib_timeout_o = tmo_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_fpga_rst_seq.sv
// tb/tb_fpga_rst_seq.sv - self-checking bench for fpga_rst_seq
module tb_fpga_rst_seq;

    localparam int DB = 16;
    localparam int DR = 4;
    localparam int SR = 8;
    localparam int CT = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b0;
    logic vio = 1'b0;
    logic lock = 1'b1;
    logic calib = 1'b1;

    logic       d_dram, d_socn, d_tmo;
    logic [2:0] d_st;
    logic       n_dram, n_socn, n_tmo;
    logic [2:0] n_st;

    fpga_rst_seq #(
        .DebounceCycles(DB), .DramRstCycles(DR), .SocRstCycles(SR),
        .CalibTimeout(CT), .UseDram(1'b1), .CntWidth(32)
    ) u_dut (
        .clk_i(clk), .rst_i(rst), .btn_rst_i(btn), .vio_rst_i(vio),
        .clk_locked_i(lock), .calib_done_i(calib),
        .dram_rst_o(d_dram), .soc_rst_no(d_socn),
        .calib_timeout_o(d_tmo), .state_o(d_st)
    );

    fpga_rst_seq #(
        .DebounceCycles(DB), .DramRstCycles(DR), .SocRstCycles(SR),
        .CalibTimeout(CT), .UseDram(1'b0), .CntWidth(32)
    ) u_dut_nodram (
        .clk_i(clk), .rst_i(rst), .btn_rst_i(btn), .vio_rst_i(vio),
        .clk_locked_i(lock), .calib_done_i(calib),
        .dram_rst_o(n_dram), .soc_rst_no(n_socn),
        .calib_timeout_o(n_tmo), .state_o(n_st)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model. Inputs are sampled at each edge; each delay line holds
    // the last two sampled values. The sequencer is tracked as "state + edge it
    // was entered at", so a timed state of N cycles ends N edges after entry.
    int   edge_n = 0;
    logic l1 = 0, l2 = 0, c1 = 0, c2 = 0, b1 = 0, b2 = 0;
    logic m_db = 0;
    int   m_run = 0;
    int   m_st[2] = '{0, 0};
    int   m_ent[2] = '{0, 0};
    logic m_tmo[2] = '{1'b0, 1'b0};

    task automatic go(input int k, input int s);
        m_st[k]  = s;
        m_ent[k] = edge_n;
    endtask

    task automatic model_step();
        logic ab;
        int   el;
        edge_n++;
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_st[k]  = 0;
                m_tmo[k] = 1'b0;
            end
            l1 = 0; l2 = 0; c1 = 0; c2 = 0; b1 = 0; b2 = 0;
            m_db = 0; m_run = 0;
            return;
        end
        ab = m_db | vio | ~l2;
        for (int k = 0; k < 2; k++) begin
            el = edge_n - m_ent[k];
            if (m_st[k] == 0) go(k, 1);
            else if (ab) go(k, 1);
            else if (m_st[k] == 1) go(k, 2);
            else if (m_st[k] == 2 && el == DR) go(k, (k == 0) ? 3 : 4);
            else if (m_st[k] == 3 && c2) go(k, 4);
            else if (m_st[k] == 3 && el == CT) begin
                m_tmo[k] = 1'b1;
                go(k, 2);
            end
            else if (m_st[k] == 4 && el == SR) go(k, 5);
        end
        // Debounced value flips after DB consecutive disagreeing edges.
        if (b2 != m_db) begin
            if (m_run == DB - 1) begin
                m_db  = b2;
                m_run = 0;
            end else begin
                m_run++;
            end
        end else begin
            m_run = 0;
        end
        l2 = l1; l1 = lock;
        c2 = c1; c1 = calib;
        b2 = b1; b1 = btn;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("state", {29'd0, d_st}, m_st[0]);
        chk("dram_rst", {31'd0, d_dram}, {31'd0, m_st[0] <= 2});
        chk("soc_rst_n", {31'd0, d_socn}, {31'd0, m_st[0] == 5});
        chk("calib_tmo", {31'd0, d_tmo}, {31'd0, m_tmo[0]});
        chk("nd_state", {29'd0, n_st}, m_st[1]);
        chk("nd_dram_rst", {31'd0, n_dram}, {31'd0, m_st[1] <= 2});
        chk("nd_soc_rst_n", {31'd0, n_socn}, {31'd0, m_st[1] == 5});
        chk("nd_calib_tmo", {31'd0, n_tmo}, {31'd0, m_tmo[1]});
    endtask

    task automatic restart(input logic cal);
        rst = 1'b1; btn = 1'b0; vio = 1'b0; lock = 1'b1; calib = cal;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_run(input string tag);
        for (int i = 0; i < 300 && d_st != 3'd5; i++) tick();
        chk(tag, {29'd0, d_st}, 5);
    endtask

    int fall_e, rise_e, nrise_e, saw3, e_hit, moved;

    initial begin
        // Reset values
        restart(1'b1);
        rst = 1'b1;
        chk("rst_state", {29'd0, d_st}, 0);
        chk("rst_dram", {31'd0, d_dram}, 1);
        chk("rst_socn", {31'd0, d_socn}, 0);
        chk("rst_tmo", {31'd0, d_tmo}, 0);

        // Clean bring-up
        restart(1'b1);
        fall_e = 0; rise_e = 0; nrise_e = 0; saw3 = 0;
        for (int e = 1; e <= 30; e++) begin
            tick();
            if (d_dram == 1'b0 && fall_e == 0) fall_e = e;
            if (d_socn == 1'b1 && rise_e == 0) rise_e = e;
            if (n_socn == 1'b1 && nrise_e == 0) nrise_e = e;
            if (n_st == 3'd3) saw3 = 1;
        end
        chk("bringup_dram_fall_edge", fall_e, 3 + DR);
        chk("bringup_soc_rise_edge", rise_e, 4 + DR + SR);
        chk("bringup_run", {29'd0, d_st}, 5);
        chk("nodram_soc_rise_edge", nrise_e, 3 + DR + SR);
        chk("nodram_skips_calib", saw3, 0);

        // Short button pulse is filtered
        btn = 1'b1;
        moved = 0;
        for (int e = 1; e <= 10; e++) begin tick(); if (d_st != 3'd5) moved = 1; end
        btn = 1'b0;
        for (int e = 1; e <= 30; e++) begin tick(); if (d_st != 3'd5) moved = 1; end
        chk("short_pulse_ignored", moved, 0);

        // Long button pulse aborts after sync + debounce + one FSM edge
        btn = 1'b1;
        e_hit = 0;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (e == 20) btn = 1'b0;
            if (d_st == 3'd1 && e_hit == 0) begin
                e_hit = e;
                chk("btn_abort_dram", {31'd0, d_dram}, 1);
                chk("btn_abort_socn", {31'd0, d_socn}, 0);
            end
        end
        chk("btn_abort_edge", e_hit, 3 + DB);
        wait_run("btn_resequence_run");

        // Calibration timeout and retry
        restart(1'b0);
        e_hit = 0;
        for (int e = 1; e <= 110; e++) begin
            tick();
            if (d_tmo == 1'b1 && e_hit == 0) begin
                e_hit = e;
                chk("tmo_retry_state", {29'd0, d_st}, 2);
            end
        end
        chk("tmo_edge", e_hit, 3 + DR + CT);
        calib = 1'b1;
        wait_run("tmo_then_run");
        chk("tmo_sticky", {31'd0, d_tmo}, 1);

        // Calibration arrives on the timeout cycle
        restart(1'b0);
        for (int e = 1; e <= 4 + DR + CT - 4; e++) tick();
        calib = 1'b1;
        tick();
        tick();
        chk("same_cycle_pre", {29'd0, d_st}, 3);
        tick();
        chk("same_cycle_state", {29'd0, d_st}, 4);
        chk("same_cycle_tmo", {31'd0, d_tmo}, 0);

        // Lock loss in SOC_RST, then VIO pulse in RUN
        restart(1'b1);
        for (int e = 1; e <= 10; e++) tick();
        chk("lock_pre_state", {29'd0, d_st}, 4);
        lock = 1'b0;
        tick();
        tick();
        chk("lock_loss_edge2", {29'd0, d_st}, 4);
        tick();
        chk("lock_loss_edge3", {29'd0, d_st}, 1);
        chk("lock_loss_dram", {31'd0, d_dram}, 1);
        lock = 1'b1;
        wait_run("lock_recover_run");
        vio = 1'b1;
        tick();
        vio = 1'b0;
        chk("vio_state", {29'd0, d_st}, 1);
        chk("vio_socn", {31'd0, d_socn}, 0);
        chk("vio_dram", {31'd0, d_dram}, 1);

        // rst_i in WAIT_CALIB after a timeout
        restart(1'b0);
        for (int e = 1; e <= 115; e++) tick();
        chk("midrst_pre_state", {29'd0, d_st}, 3);
        rst = 1'b1;
        tick();
        chk("midrst_state", {29'd0, d_st}, 0);
        chk("midrst_dram", {31'd0, d_dram}, 1);
        chk("midrst_socn", {31'd0, d_socn}, 0);
        chk("midrst_tmo", {31'd0, d_tmo}, 0);
        rst = 1'b0;

        // Random traffic against the model
        btn = 1'b0; lock = 1'b1; calib = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            if (btn) begin
                if ($urandom_range(11) == 0) btn = 1'b0;
            end else if ($urandom_range(149) == 0) btn = 1'b1;
            if (lock) begin
                if ($urandom_range(399) == 0) lock = 1'b0;
            end else if ($urandom_range(4) == 0) lock = 1'b1;
            if (calib) begin
                if ($urandom_range(199) == 0) calib = 1'b0;
            end else if ($urandom_range(59) == 0) calib = 1'b1;
            vio = ($urandom_range(499) == 0);
            rst = ($urandom_range(999) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
